lag_measure: RTL and testbench
==============================

// Module: lag_measure
// PURPOSE
//  Measures display lag: the time from the frame-generator start pulse (first white-field frame) to
//  the photo sensor detecting light on screen. Result is a 4-digit BCD value in 0.1 ms units
//  (000.0..999.9 ms). The result feeds the lag text renderer that builds the overlay line bitmap.
//  Sits downstream of the frame generator (starttrigger) and upstream of the overlay/text stage.
// PARAMETERS
//  TICK_DIV   7425  clock cycles per 0.1 ms tick (74.25 MHz pixel clock); must be >=2
//  DEBOUNCE   16    consecutive synced-high cycles before the sensor counts as lit; must be >=1
//  SYNC_STAGES 2    sensor synchroniser depth; must be >=2
// PORTS
//  clock          in   1   pixel clock
//  reset          in   1   synchronous, active-high
//  starttrigger   in   1   1-cycle pulse, start of a measurement
//  sensor         in   1   asynchronous photo sensor, 1 = light detected
//  lag_bcd        out  16  last valid result, BCD {hundreds,tens,units,tenths} of ms
//  lag_valid      out  1   1-cycle pulse, lag_bcd updated this cycle
//  timeout        out  1   1-cycle pulse, measurement aborted at 999.9 ms
//  busy           out  1   1 while a measurement is running (WAIT_DARK or COUNT)
// BEHAVIOUR
//  Reset: state=IDLE; lag_bcd=0, lag_valid=0, timeout=0, busy=0; prescaler, BCD counter,
//   synchroniser and debounce counter cleared. Reset mid-measurement aborts it with no pulses.
//  Sensor path: SYNC_STAGES flops -> debounce counter (saturating). sensor_db=1 once synced input
//   has been 1 for DEBOUNCE consecutive cycles; drops to 0 on the first synced 0. Runs in all states.
//  FSM states: IDLE, WAIT_DARK, COUNT.
//   IDLE: starttrigger=1 -> WAIT_DARK; prescaler<=0, bcd<=0 in the same edge.
//   WAIT_DARK: timing runs; sensor_db=0 -> COUNT (screen must be seen dark before lit counts).
//   COUNT: timing runs; sensor_db=1 -> lag_bcd<=bcd (value held on that cycle), lag_valid=1
//    next cycle, -> IDLE.
//   WAIT_DARK/COUNT timeout: prescaler==TICK_DIV-1 and bcd==16'h9999 -> timeout=1, -> IDLE,
//    lag_bcd unchanged.
//  Timing: in WAIT_DARK/COUNT, prescaler increments every cycle. At TICK_DIV-1 it wraps to 0 and
//   bcd increments with decimal carry per nibble (9->0, carry up). bcd = floor(k/TICK_DIV), where
//   k = cycles since entry to WAIT_DARK. Result includes SYNC_STAGES+DEBOUNCE cycles of filter
//   latency; downstream does not correct it.
//  Precedence same cycle: detection beats timeout (lag_valid=1, lag_bcd=16'h9999, timeout=0).
//  starttrigger while busy=1 is ignored (no restart). starttrigger in the same cycle as a
//   detection/timeout return to IDLE is ignored.
//  Outputs registered; lag_valid and timeout never both 1; busy=1 exactly in WAIT_DARK/COUNT.
// TESTING  (bench: TICK_DIV=4, DEBOUNCE=2, SYNC_STAGES=2)
//  1 reset, sensor=0, pulse starttrigger; sensor_db rises exactly 41 cycles after entry to
//    WAIT_DARK -> lag_valid 1 cycle later, lag_bcd=16'h0010, busy then 0.
//  2 sensor held 1 through start, released after 20 cycles, raised again -> no result until
//    sensor_db re-asserts; lag_bcd = floor(k/4) measured from start, in BCD.
//  3 sensor never lit -> timeout pulse after 40000 cycles in WAIT_DARK/COUNT, lag_bcd keeps
//    previous value, busy=0.
//  4 1-cycle sensor glitches (< DEBOUNCE) during COUNT -> ignored; measurement continues.
//  5 starttrigger pulsed again mid-measurement -> ignored; result timed from the first pulse.
//  6 reset asserted mid-COUNT -> all outputs 0 next cycle, no lag_valid/timeout; a new start works.
//  7 BCD carry: detect at k=4*1000 -> lag_bcd=16'h1000; detection on the timeout cycle ->
//    lag_valid, lag_bcd=16'h9999, no timeout.

Source files
------------

// File: rtl/lag_measure.sv
// Display lag meter: times from the frame-generator start pulse to the photo
// sensor seeing light. The result is 4-digit BCD in 0.1 ms units. The sensor
// is synchronised and debounced, and the screen must first be seen dark.
module lag_measure #(
  parameter int TICK_DIV    = 7425,
  parameter int DEBOUNCE    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        starttrigger,
  input  logic        sensor,
  output logic [15:0] lag_bcd,
  output logic        lag_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_SAT     = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DARK, COUNT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          db_cnt;
  logic                   synced;
  logic                   sensor_db;
  logic [PW-1:0]          presc;
  logic [15:0]            bcd;
  logic [15:0]            bcd_next;
  logic                   carry;
  logic                   last_tick;

  assign synced    = sync[SYNC_STAGES-1];
  // db_cnt holds the number of earlier consecutive high cycles, so the
  // current high cycle completes the run and a low cycle drops it at once.
  assign sensor_db = synced && (db_cnt == DB_SAT);
  assign last_tick = (presc == PRESC_LAST);

  // Sensor synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], sensor};
  end

  // Saturating count of consecutive synced-high cycles.
  always_ff @(posedge clock) begin
    if (reset || !synced)    db_cnt <= '0;
    else if (db_cnt != DB_SAT) db_cnt <= db_cnt + DW'(1);
  end

  // Decimal increment of the 4-digit tick counter.
  always_comb begin
    bcd_next = bcd;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_next[4*i +: 4] = 4'd0;
        end else begin
          bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Measurement FSM with timing counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      bcd       <= '0;
      lag_bcd   <= '0;
      lag_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      lag_valid <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (starttrigger) begin
            state <= WAIT_DARK;
            presc <= '0;
            bcd   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_DARK, COUNT: begin
          // Detection wins over a simultaneous timeout.
          if (state == COUNT && sensor_db) begin
            lag_bcd   <= bcd;
            lag_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (last_tick && bcd == 16'h9999) begin
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            // A lit reading only counts after the screen was seen dark.
            if (state == WAIT_DARK && !sensor_db) state <= COUNT;
            if (last_tick) begin
              presc <= '0;
              bcd   <= bcd_next;
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lag_measure.sv
// Bench for lag_measure: directed scenarios plus random sensor/start/reset
// traffic, checked against a cycle-count reference model.
module tb_lag_measure;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int SS = 2;
  localparam int KMAX = TD * 10000 - 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        starttrigger;
  logic        sensor;
  logic [15:0] lag_bcd;
  logic        lag_valid;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  lag_measure #(.TICK_DIV(TD), .DEBOUNCE(DB), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .starttrigger(starttrigger), .sensor(sensor),
    .lag_bcd(lag_bcd), .lag_valid(lag_valid), .timeout(timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: sensor history per edge, elapsed cycle count k and
  // a "dark seen" flag; the result is k/TD rendered in decimal.
  bit          hist [0:SS+DB-2];
  logic [15:0] m_lag;
  logic        m_valid, m_to, m_busy;
  bit          m_dark;
  int          m_k;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clock) begin
    bit db;
    // Lit when the synced value and the DB-1 before it were all high.
    db = 1'b1;
    for (int j = SS - 1; j <= SS + DB - 2; j++) if (!hist[j]) db = 1'b0;
    for (int j = SS + DB - 2; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = sensor;
    if (reset) begin
      for (int j = 0; j <= SS + DB - 2; j++) hist[j] = 1'b0;
      m_lag = 16'h0; m_valid = 1'b0; m_to = 1'b0; m_busy = 1'b0;
      m_dark = 1'b0; m_k = 0;
    end else begin
      m_valid = 1'b0;
      m_to = 1'b0;
      if (!m_busy) begin
        if (starttrigger) begin m_busy = 1'b1; m_dark = 1'b0; m_k = 0; end
      end else if (m_dark && db) begin
        m_lag = to_bcd(m_k / TD); m_valid = 1'b1; m_busy = 1'b0;
      end else if (m_k == KMAX) begin
        m_to = 1'b1; m_busy = 1'b0;
      end else begin
        if (!db) m_dark = 1'b1;
        m_k++;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    starttrigger = 1'b1;
    cyc();
    starttrigger = 1'b0;
  endtask

  // Waits up to maxc cycles for lag_valid or timeout; n=-1 if none came.
  task automatic wait_pulse(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      cyc();
      if (lag_valid || timeout) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sensor = 1'b1; starttrigger = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({lag_bcd, lag_valid, timeout, busy} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs: got %h/%b/%b/%b want 0", lag_bcd, lag_valid, timeout, busy);
    end
    reset = 1'b0; sensor = 1'b0; starttrigger = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_basic();
    int n;
    start_pulse();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    repeat (41 - 3) cyc();
    sensor = 1'b1;
    wait_pulse(20, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", n); end
    checks++;
    if ({lag_bcd, lag_valid, timeout, busy} !== {16'h0010, 3'b100}) begin
      errors++; $display("FAIL basic_result: got %h/%b/%b/%b want 0010/1/0/0", lag_bcd, lag_valid, timeout, busy);
    end
    cyc();
    checks++;
    if (lag_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", lag_valid); end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_timeout();
    int n;
    start_pulse();
    wait_pulse(KMAX + 100, n);
    checks++;
    if (n !== KMAX + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", n, KMAX + 1); end
    checks++;
    if ({lag_bcd, lag_valid, timeout, busy} !== {16'h0010, 3'b010}) begin
      errors++; $display("FAIL timeout_result: got %h/%b/%b/%b want 0010/0/1/0", lag_bcd, lag_valid, timeout, busy);
    end
    cyc();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", timeout); end
    repeat (3) cyc();
  endtask

  task automatic test_relit();
    int n;
    sensor = 1'b1;
    repeat (5) cyc();
    start_pulse();
    repeat (20) cyc();
    sensor = 1'b0;
    repeat (5) cyc();
    sensor = 1'b1;
    wait_pulse(30, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL relit_latency: got %0d want 4", n); end
    checks++;
    if (lag_bcd !== 16'h0007 || lag_bcd !== m_lag || lag_valid !== 1'b1) begin
      errors++; $display("FAIL relit_result: got %h/%b want 0007/1 (model %h)", lag_bcd, lag_valid, m_lag);
    end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_glitch();
    int n;
    start_pulse();
    for (int i = 1; i <= 60; i++) begin
      cyc();
      sensor = (i == 10 || i == 20 || i == 30 || i == 60);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b want 1", busy); end
    wait_pulse(20, n);
    checks++;
    if (n !== 4 || lag_bcd !== 16'h0015) begin
      errors++; $display("FAIL glitch_result: got n=%0d lag=%h want n=4 lag=0015", n, lag_bcd);
    end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_restart();
    int n;
    start_pulse();
    for (int i = 1; i <= 78; i++) begin
      cyc();
      starttrigger = (i == 10);
    end
    sensor = 1'b1;
    wait_pulse(20, n);
    checks++;
    if (n !== 4 || lag_bcd !== 16'h0020) begin
      errors++; $display("FAIL restart_result: got n=%0d lag=%h want n=4 lag=0020", n, lag_bcd);
    end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_back_to_back();
    int n;
    start_pulse();
    repeat (41 - 3) cyc();
    sensor = 1'b1;
    repeat (3) cyc();
    starttrigger = 1'b1;
    cyc();
    starttrigger = 1'b0;
    checks++;
    if (lag_valid !== 1'b1 || lag_bcd !== 16'h0010) begin
      errors++; $display("FAIL b2b_first: got %b/%h want 1/0010", lag_valid, lag_bcd);
    end
    sensor = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_return: busy got %b want 0", busy); end
    repeat (2) cyc();
    start_pulse();
    repeat (45 - 3) cyc();
    sensor = 1'b1;
    wait_pulse(20, n);
    checks++;
    if (n !== 4 || lag_bcd !== 16'h0011) begin
      errors++; $display("FAIL b2b_second: got n=%0d lag=%h want n=4 lag=0011", n, lag_bcd);
    end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid();
    int n;
    start_pulse();
    repeat (30) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({lag_bcd, lag_valid, timeout, busy} !== 19'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h/%b/%b/%b want 0", lag_bcd, lag_valid, timeout, busy);
    end
    wait_pulse(20, n);
    checks++;
    if (n !== -1) begin errors++; $display("FAIL reset_mid_no_pulse: got pulse at %0d want none", n); end
    start_pulse();
    repeat (41 - 3) cyc();
    sensor = 1'b1;
    wait_pulse(20, n);
    checks++;
    if (n !== 4 || lag_bcd !== 16'h0010) begin
      errors++; $display("FAIL reset_mid_restart: got n=%0d lag=%h want n=4 lag=0010", n, lag_bcd);
    end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_bcd_carry();
    int n;
    start_pulse();
    repeat (4000 - 3) cyc();
    sensor = 1'b1;
    wait_pulse(20, n);
    checks++;
    if (n !== 4 || lag_bcd !== 16'h1000) begin
      errors++; $display("FAIL carry_1000: got n=%0d lag=%h want n=4 lag=1000", n, lag_bcd);
    end
    sensor = 1'b0;
    repeat (4) cyc();
    start_pulse();
    repeat (KMAX - 3) cyc();
    sensor = 1'b1;
    wait_pulse(20, n);
    checks++;
    if (n !== 4 || {lag_bcd, lag_valid, timeout} !== {16'h9999, 2'b10}) begin
      errors++; $display("FAIL detect_on_timeout: got n=%0d %h/%b/%b want n=4 9999/1/0", n, lag_bcd, lag_valid, timeout);
    end
    sensor = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_random();
    int results;
    results = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) sensor = ~sensor;
      starttrigger = ($urandom_range(15) == 0);
      reset = ($urandom_range(499) == 0);
      cyc();
      if (lag_valid) results++;
      checks++;
      if ({lag_bcd, lag_valid, timeout, busy} !== {m_lag, m_valid, m_to, m_busy}) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 lag_bcd, lag_valid, timeout, busy, m_lag, m_valid, m_to, m_busy);
      end
    end
    reset = 1'b0; starttrigger = 1'b0; sensor = 1'b0;
    checks++;
    if (results < 5) begin errors++; $display("FAIL random_activity: got %0d results want >=5", results); end
  endtask

  initial begin
    reset = 1'b1; starttrigger = 1'b0; sensor = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_relit();
    test_glitch();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_bcd_carry();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
